// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module : fetch_stage
// Brief  : Instruction fetch front end: PC, credit-limited imem requests,
//          in-order response FIFO feeding decode, redirect with stale drop.
// Rev    : 1.0  initial release
// ============================================================================
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc
);

  localparam int unsigned c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned c_cnt_w = $clog2(DEPTH + 1);
  localparam int unsigned c_sum_w = c_cnt_w + 2;
  localparam logic [31:0] c_nop   = 32'h0000_0013;

  typedef logic [c_ptr_w-1:0] ptr_t;
  typedef logic [c_cnt_w-1:0] cnt_t;

  localparam ptr_t c_last = ptr_t'(DEPTH - 1);

  function automatic ptr_t f_next(input ptr_t p);
    return (p == c_last) ? '0 : p + 1'b1;
  endfunction

  logic [31:0] r_pc;
  logic [31:0] r_tag_mem    [DEPTH];
  logic [31:0] r_fifo_pc    [DEPTH];
  logic [31:0] r_fifo_instr [DEPTH];
  ptr_t        r_tag_wr;
  ptr_t        r_tag_rd;
  ptr_t        r_fifo_wr;
  ptr_t        r_fifo_rd;
  cnt_t        r_outstanding;
  cnt_t        r_drop;
  cnt_t        r_count;

  logic [c_sum_w-1:0] w_used;
  cnt_t               w_stale;
  logic               w_req_fire;
  logic               w_rsp_drop;
  logic               w_rsp_take;
  logic               w_pop;
  logic               w_redir_eats_rsp;
  logic               w_unused_redirect_lsbs;

  // Credits count everything that will eventually occupy a FIFO slot or a
  // response beat, including stale responses still owed after a redirect.
  assign w_used = c_sum_w'(r_outstanding) + c_sum_w'(r_count) + c_sum_w'(r_drop);
  assign w_stale = r_drop + r_outstanding;

  assign imem_req_valid = !rst && !redirect_valid && (w_used < c_sum_w'(DEPTH));
  assign imem_req_addr  = r_pc;

  assign w_req_fire       = imem_req_valid && imem_req_ready;
  assign w_rsp_drop       = imem_rsp_valid && (r_drop != '0);
  assign w_rsp_take       = imem_rsp_valid && !redirect_valid && (r_drop == '0)
                            && (r_outstanding != '0);
  assign w_pop            = id_valid && id_ready && !redirect_valid;
  assign w_redir_eats_rsp = imem_rsp_valid && (w_stale != '0);

  assign w_unused_redirect_lsbs = ^redirect_pc[1:0];

  assign id_valid = (r_count != '0);
  assign id_instr = id_valid ? r_fifo_instr[r_fifo_rd] : c_nop;
  assign id_pc    = id_valid ? r_fifo_pc[r_fifo_rd]    : 32'h0000_0000;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc          <= RESET_PC;
      r_tag_wr      <= '0;
      r_tag_rd      <= '0;
      r_fifo_wr     <= '0;
      r_fifo_rd     <= '0;
      r_outstanding <= '0;
      r_drop        <= '0;
      r_count       <= '0;
    end else if (redirect_valid) begin
      // Every request still in flight becomes a response to be discarded.
      r_pc          <= {redirect_pc[31:2], 2'b00};
      r_tag_wr      <= '0;
      r_tag_rd      <= '0;
      r_fifo_wr     <= '0;
      r_fifo_rd     <= '0;
      r_outstanding <= '0;
      r_count       <= '0;
      r_drop        <= w_stale - cnt_t'(w_redir_eats_rsp);
    end else begin
      if (w_req_fire) begin
        r_pc     <= r_pc + 32'd4;
        r_tag_wr <= f_next(r_tag_wr);
      end
      if (w_rsp_take) begin
        r_tag_rd  <= f_next(r_tag_rd);
        r_fifo_wr <= f_next(r_fifo_wr);
      end
      if (w_pop) begin
        r_fifo_rd <= f_next(r_fifo_rd);
      end
      if (w_rsp_drop) begin
        r_drop <= r_drop - 1'b1;
      end
      r_outstanding <= r_outstanding + cnt_t'(w_req_fire) - cnt_t'(w_rsp_take);
      r_count       <= r_count + cnt_t'(w_rsp_take) - cnt_t'(w_pop);
    end
  end

  // Storage arrays carry no reset; validity lives in the pointers and counts.
  always_ff @(posedge clk) begin
    if (w_req_fire) begin
      r_tag_mem[r_tag_wr] <= r_pc;
    end
    if (w_rsp_take) begin
      r_fifo_pc[r_fifo_wr]    <= r_tag_mem[r_tag_rd];
      r_fifo_instr[r_fifo_wr] <= imem_rsp_data;
    end
  end

  a_rsp_has_owner: assert property (@(posedge clk) disable iff (rst)
    imem_rsp_valid |-> (w_stale != '0));

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module : tb_fetch_stage
// Brief  : Randomized bench for fetch_stage against an epoch-based memory and
//          decode-stream reference model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_fetch_stage;

  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [31:0] id_instr;
  logic [31:0] id_pc;

  fetch_stage #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) u_dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_instr       (id_instr),
    .id_pc          (id_pc)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Memory request in flight; epoch marks which redirect generation owns it.
  typedef struct packed {
    logic [31:0] addr;
    int          due;
    int          epoch;
  } req_t;

  req_t        mq[$];
  logic [63:0] fq[$];
  logic [31:0] m_pc  = RESET_PC;
  int          epoch = 0;
  int          cyc   = 0;
  int          m_lat = 1;
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] image(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'hFFF1_2383;
      32'h0000_0004: return 32'h00F1_2323;
      32'h0000_0008: return 32'hFE51_2EE3;
      default:       return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endcase
  endfunction

  // Entered just after a rising edge; drives one cycle, checks at the falling
  // edge, advances the model, and returns just after the next rising edge.
  task automatic cycle(input logic rdy, input logic idr, input logic rd, input logic [31:0] rpc);
    logic        exp_rv;
    logic        rsp;
    logic [63:0] head;
    req_t        ent;
    imem_req_ready = rdy;
    id_ready       = idr;
    redirect_valid = rd;
    redirect_pc    = rpc;
    rsp            = (mq.size() > 0) && (mq[0].due <= cyc);
    imem_rsp_valid = rsp;
    imem_rsp_data  = rsp ? image(mq[0].addr) : $urandom();
    @(negedge clk);
    exp_rv = !rd && ((mq.size() + fq.size()) < DEPTH);
    head   = (fq.size() > 0) ? fq[0] : {32'h0, NOP};
    check("req_valid", 32'(imem_req_valid), 32'(exp_rv));
    check("req_addr", imem_req_addr, m_pc);
    check("id_valid", 32'(id_valid), 32'(fq.size() > 0));
    check("id_pc", id_pc, head[63:32]);
    check("id_instr", id_instr, head[31:0]);
    if (!rd && idr && fq.size() > 0) void'(fq.pop_front());
    if (rsp) begin
      ent = mq.pop_front();
      if (!rd && ent.epoch == epoch) fq.push_back({ent.addr, image(ent.addr)});
    end
    if (rd) begin
      fq.delete();
      m_pc = {rpc[31:2], 2'b00};
      epoch++;
    end else if (exp_rv && rdy) begin
      mq.push_back('{addr: m_pc, due: cyc + m_lat, epoch: epoch});
      m_pc = m_pc + 32'd4;
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic async_reset();
    #2;
    rst = 1'b1;
    #1;
    check("arst_id_valid", 32'(id_valid), 0);
    check("arst_req_valid", 32'(imem_req_valid), 0);
    check("arst_id_instr", id_instr, NOP);
    check("arst_id_pc", id_pc, 0);
    mq.delete();
    fq.delete();
    m_pc           = RESET_PC;
    imem_rsp_valid = 1'b0;
    redirect_valid = 1'b0;
    imem_req_ready = 1'b0;
    id_ready       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  logic [31:0] boot [3];
  int          boot_n;
  logic [31:0] first_pc;
  logic        seen;
  logic        ready_found;
  logic [3:0]  rdy_pat;

  initial begin
    boot[0] = 32'hFFF1_2383;
    boot[1] = 32'h00F1_2323;
    boot[2] = 32'hFE51_2EE3;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_valid", 32'(imem_req_valid), 0);
    check("rst_id_valid", 32'(id_valid), 0);
    check("rst_id_instr", id_instr, NOP);
    check("rst_id_pc", id_pc, 0);
    rst = 1'b0;

    // Streaming from reset, single-cycle memory
    m_lat  = 1;
    boot_n = 0;
    for (int i = 0; i < 14; i++) begin
      cycle(1'b1, 1'b1, 1'b0, 32'h0);
      if (id_valid && boot_n < 3) begin
        check("boot_instr", id_instr, boot[boot_n]);
        check("boot_pc", id_pc, 32'(boot_n * 4));
        boot_n++;
      end
    end
    check("boot_count", 32'(boot_n), 3);

    // Decode stall, then release
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 1'b0, 32'h0);
    check("stall_full", 32'(id_valid), 1);
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b1, 1'b0, 32'h0);

    // Redirect with two requests outstanding
    m_lat = 3;
    for (int i = 0; i < 20 && mq.size() < 2; i++) cycle(1'b1, 1'b1, 1'b0, 32'h0);
    check("pre_redirect_outstanding", 32'(mq.size()), 2);
    cycle(1'b1, 1'b1, 1'b1, 32'h0000_0102);
    seen     = 1'b0;
    first_pc = '0;
    for (int i = 0; i < 20; i++) begin
      if (!seen && id_valid) begin
        first_pc = id_pc;
        seen     = 1'b1;
      end
      cycle(1'b1, 1'b1, 1'b0, 32'h0);
    end
    check("redirect_seen", 32'(seen), 1);
    check("redirect_first_pc", first_pc, 32'h0000_0100);

    // Redirect colliding with a response and an id handshake
    m_lat       = 2;
    ready_found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (fq.size() > 0 && mq.size() > 0 && mq[0].due <= cyc) begin
        ready_found = 1'b1;
        break;
      end
      cycle(1'b1, 1'b0, 1'b0, 32'h0);
    end
    check("collide_setup", 32'(ready_found), 1);
    cycle(1'b1, 1'b1, 1'b1, 32'h0000_0200);
    check("collide_flush", 32'(id_valid), 0);
    for (int i = 0; i < 12; i++) cycle(1'b1, 1'b1, 1'b0, 32'h0);

    // Memory back-pressure 1,0,0,1 with three-cycle latency
    m_lat   = 3;
    rdy_pat = 4'b1001;
    for (int i = 0; i < 24; i++) cycle(rdy_pat[i % 4], 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b1, 1'b0, 32'h0);

    // Asynchronous reset in the middle of a stall
    m_lat = 1;
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 1'b0, 32'h0);
    async_reset();
    check("post_reset_addr", imem_req_addr, RESET_PC);
    for (int i = 0; i < 12; i++) cycle(1'b1, 1'b1, 1'b0, 32'h0);

    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      m_lat = int'($urandom_range(1, 4));
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 19) == 0, $urandom());
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
